// File: rtl/f_fetch_stage_pkg.sv
// Shared constants and types for the fetch stage: exception codes, reset and
// handler addresses, the legal instruction-memory window and the control FSM
// state encoding.
package f_fetch_stage_pkg;

  // Exception codes reported alongside a fetched instruction
  localparam logic [4:0] EXC_NONE = 5'd0;
  localparam logic [4:0] EXC_ADEL = 5'd4;

  // Architectural fetch addresses
  localparam logic [31:0] PC_RESET  = 32'h0000_3000;
  localparam logic [31:0] EXC_ENTRY = 32'h0000_4180;

  // Inclusive legal fetch window of the instruction memory
  localparam logic [31:0] IM_LO = 32'h0000_3000;
  localparam logic [31:0] IM_HI = 32'h0000_6FFC;

  // Control FSM: RUN is normal flow, FLUSHED marks that the F/D register
  // currently holds a flush bubble, so any D_is_jump seen is stale.
  typedef enum logic {
    FS_RUN     = 1'b0,
    FS_FLUSHED = 1'b1
  } fs_state_t;

  // Contents of the F/D pipeline register
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [4:0]  exc_code;
    logic        bd;
  } fd_reg_t;

  // Load address error: misaligned word fetch or outside [lo, hi] (unsigned)
  function automatic logic fetch_adel(input logic [31:0] addr,
                                      input logic [31:0] lo,
                                      input logic [31:0] hi);
    return (addr[1:0] != 2'b00) || (addr < lo) || (addr > hi);
  endfunction

endpackage

// File: rtl/f_fetch_stage_pc_reg.sv
// f_pc_reg: architectural fetch PC. An exception request redirects to the
// handler even while the hazard unit stalls; otherwise a stall holds the PC
// and a free edge takes the next PC from decode.
module f_pc_reg #(
  parameter logic [31:0] PC_RESET  = f_fetch_stage_pkg::PC_RESET,
  parameter logic [31:0] EXC_ENTRY = f_fetch_stage_pkg::EXC_ENTRY
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        stall,
  input  logic [31:0] npc,
  output logic [31:0] pc
);

  logic [31:0] pc_reg;
  logic [31:0] pc_next;

  // Next-PC selection: req beats stall, stall beats npc
  always_comb begin
    pc_next = pc_reg;
    if (req) begin
      pc_next = EXC_ENTRY;
    end else if (!stall) begin
      pc_next = npc;
    end
  end

  // PC register with asynchronous reset to the boot address
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_reg <= PC_RESET;
    end else begin
      pc_reg <= pc_next;
    end
  end

  assign pc = pc_reg;

endmodule

// File: rtl/f_fetch_stage.sv
// f_fetch_stage: fetch stage of the five-stage MIPS pipeline. Drives the
// instruction-memory address straight from the PC register, flags fetch
// address errors and owns the F/D pipeline register feeding decode.
// Build option: define F_ADEL_CHECK_EN to enable AdEL detection on fetch;
// without it the fetched word is always passed through and F_excCode is 0.
module f_fetch_stage #(
  parameter logic [31:0] PC_RESET  = f_fetch_stage_pkg::PC_RESET,
  parameter logic [31:0] EXC_ENTRY = f_fetch_stage_pkg::EXC_ENTRY
`ifdef F_ADEL_CHECK_EN
  // The legal window only exists when the address check is built in
  , parameter logic [31:0] IM_LO = f_fetch_stage_pkg::IM_LO
  , parameter logic [31:0] IM_HI = f_fetch_stage_pkg::IM_HI
`endif
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] npc,
  input  logic        stall,
  input  logic        req,
  input  logic        eret,
  input  logic        D_is_jump,
  output logic [31:0] i_inst_addr,
  input  logic [31:0] i_inst_rdata,
  output logic [31:0] F_pc,
  output logic [4:0]  F_excCode,
  output logic [31:0] D_pc,
  output logic [31:0] D_instr,
  output logic [4:0]  D_excCode,
  output logic        D_bd
);

  import f_fetch_stage_pkg::*;

  logic [31:0] pc;
  logic [31:0] fetch_word;
  logic [4:0]  fetch_exc;
  logic        eret_flush;
  logic        bd_allow;
  fs_state_t   state_reg;
  fs_state_t   state_next;
  fd_reg_t     fd_reg;
  fd_reg_t     fd_next;

  f_pc_reg #(
    .PC_RESET  (PC_RESET),
    .EXC_ENTRY (EXC_ENTRY)
  ) u_pc_reg (
    .clk   (clk),
    .reset (reset),
    .req   (req),
    .stall (stall),
    .npc   (npc),
    .pc    (pc)
  );

  // Zero-latency fetch: the memory address is the PC register itself
  assign F_pc        = pc;
  assign i_inst_addr = pc;

`ifdef F_ADEL_CHECK_EN
  logic fetch_bad;

  // AdEL check; a faulting fetch forwards a nop instead of memory data
  always_comb begin
    fetch_bad  = fetch_adel(pc, IM_LO, IM_HI);
    fetch_exc  = fetch_bad ? EXC_ADEL : EXC_NONE;
    fetch_word = fetch_bad ? 32'h0000_0000 : i_inst_rdata;
  end
`else
  // No address check: whatever memory returns is passed to decode
  always_comb begin
    fetch_exc  = EXC_NONE;
    fetch_word = i_inst_rdata;
  end
`endif

  assign F_excCode = fetch_exc;

  // ERET only discards the sequential fetch when the pipe actually advances
  assign eret_flush = eret && !stall;

  // FSM state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= FS_RUN;
    end else begin
      state_reg <= state_next;
    end
  end

  // FSM next state: any flush enters FLUSHED, the next free edge leaves it
  always_comb begin
    state_next = state_reg;
    if (req) begin
      state_next = FS_FLUSHED;
    end else if (!stall) begin
      state_next = eret_flush ? FS_FLUSHED : FS_RUN;
    end
  end

  // FSM outputs: a delay-slot mark is only trusted in normal flow
  always_comb begin
    bd_allow = (state_reg == FS_RUN);
  end

  // F/D next value: flush on req, hold on stall, flush on eret, else load
  always_comb begin
    fd_next = fd_reg;
    if (req) begin
      // Keep a meaningful macro-PC pointing at the handler entry
      fd_next.pc       = EXC_ENTRY;
      fd_next.instr    = 32'h0000_0000;
      fd_next.exc_code = EXC_NONE;
      fd_next.bd       = 1'b0;
    end else if (stall) begin
      fd_next = fd_reg;
    end else if (eret_flush) begin
      fd_next.pc       = pc;
      fd_next.instr    = 32'h0000_0000;
      fd_next.exc_code = EXC_NONE;
      fd_next.bd       = 1'b0;
    end else begin
      fd_next.pc       = pc;
      fd_next.instr    = fetch_word;
      fd_next.exc_code = fetch_exc;
      fd_next.bd       = D_is_jump && bd_allow;
    end
  end

  // F/D pipeline register; async reset parks it at the boot address as a nop
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fd_reg.pc       <= PC_RESET;
      fd_reg.instr    <= 32'h0000_0000;
      fd_reg.exc_code <= EXC_NONE;
      fd_reg.bd       <= 1'b0;
    end else begin
      fd_reg <= fd_next;
    end
  end

  assign D_pc      = fd_reg.pc;
  assign D_instr   = fd_reg.instr;
  assign D_excCode = fd_reg.exc_code;
  assign D_bd      = fd_reg.bd;

endmodule

// File: tb/tb_f_fetch_stage.sv
// Bench for f_fetch_stage: directed vectors with hand-computed expectations
// plus a cycle-by-cycle reference model of the fetch/decode boundary.
module tb_f_fetch_stage;

  localparam logic [31:0] PC_RST  = 32'h0000_3000;
  localparam logic [31:0] EXC_ENT = 32'h0000_4180;
`ifdef F_ADEL_CHECK_EN
  localparam bit         ADEL_ON   = 1'b1;
  localparam logic [4:0] ADEL_CODE = 5'd4;
`else
  localparam bit         ADEL_ON   = 1'b0;
  localparam logic [4:0] ADEL_CODE = 5'd0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] npc = 32'h0;
  logic        stall = 1'b0;
  logic        req = 1'b0;
  logic        eret = 1'b0;
  logic        D_is_jump = 1'b0;
  logic [31:0] i_inst_addr;
  logic [31:0] i_inst_rdata;
  logic [31:0] F_pc;
  logic [4:0]  F_excCode;
  logic [31:0] D_pc;
  logic [31:0] D_instr;
  logic [4:0]  D_excCode;
  logic        D_bd;

  int n_vec = 0;
  int n_err = 0;
  bit chk_on = 1'b0;

  always #5 clk = ~clk;

  f_fetch_stage dut (
    .clk          (clk),
    .reset        (reset),
    .npc          (npc),
    .stall        (stall),
    .req          (req),
    .eret         (eret),
    .D_is_jump    (D_is_jump),
    .i_inst_addr  (i_inst_addr),
    .i_inst_rdata (i_inst_rdata),
    .F_pc         (F_pc),
    .F_excCode    (F_excCode),
    .D_pc         (D_pc),
    .D_instr      (D_instr),
    .D_excCode    (D_excCode),
    .D_bd         (D_bd)
  );

  // Instruction memory contents: distinct, never-zero word per address
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return 32'hC000_0000 ^ {a[15:0], ~a[15:0]};
  endfunction

  assign i_inst_rdata = mem_word(i_inst_addr);

  function automatic bit addr_bad(input logic [31:0] a);
    return ADEL_ON && ((a[1:0] != 2'b00) || (a < 32'h0000_3000) || (a > 32'h0000_6FFC));
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: fetch PC, what decode holds, and whether decode's
  // current contents came from a flush
  logic [31:0] m_pc, m_dpc, m_dinstr;
  logic [4:0]  m_dexc;
  logic        m_dbd, m_flushed;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_pc      <= PC_RST;
      m_dpc     <= PC_RST;
      m_dinstr  <= 32'h0;
      m_dexc    <= 5'd0;
      m_dbd     <= 1'b0;
      m_flushed <= 1'b0;
    end else if (req) begin
      m_pc      <= EXC_ENT;
      m_dpc     <= EXC_ENT;
      m_dinstr  <= 32'h0;
      m_dexc    <= 5'd0;
      m_dbd     <= 1'b0;
      m_flushed <= 1'b1;
    end else if (!stall) begin
      m_pc  <= npc;
      m_dpc <= m_pc;
      if (eret) begin
        m_dinstr  <= 32'h0;
        m_dexc    <= 5'd0;
        m_dbd     <= 1'b0;
        m_flushed <= 1'b1;
      end else begin
        m_dinstr  <= addr_bad(m_pc) ? 32'h0 : mem_word(m_pc);
        m_dexc    <= addr_bad(m_pc) ? 5'd4 : 5'd0;
        m_dbd     <= D_is_jump && !m_flushed;
        m_flushed <= 1'b0;
      end
    end
  end

  // Compare every output against the model once per cycle
  always @(negedge clk) begin
    if (chk_on) begin
      chk("F_pc", F_pc, m_pc);
      chk("i_inst_addr", i_inst_addr, m_pc);
      chk("F_excCode", {27'd0, F_excCode}, addr_bad(m_pc) ? 32'd4 : 32'd0);
      chk("D_pc", D_pc, m_dpc);
      chk("D_instr", D_instr, m_dinstr);
      chk("D_excCode", {27'd0, D_excCode}, {27'd0, m_dexc});
      chk("D_bd", {31'd0, D_bd}, {31'd0, m_dbd});
      $display("cycle t=%0t F_pc=%h D_pc=%h D_instr=%h D_exc=%0d D_bd=%0b",
               $time, F_pc, D_pc, D_instr, D_excCode, D_bd);
    end
  end

  task automatic cyc(input logic [31:0] n, input bit s, input bit r, input bit e, input bit j);
    npc = n; stall = s; req = r; eret = e; D_is_jump = j;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #1 reset = 1'b1;
    chk_on = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1 reset = 1'b0;
    chk("rst F_pc", F_pc, 32'h0000_3000);
    chk("rst D_pc", D_pc, 32'h0000_3000);
    chk("rst D_instr", D_instr, 32'h0);
    chk("rst D_bd", {31'd0, D_bd}, 32'd0);

    // Sequential fetch, D trails by one
    cyc(32'h3004, 0, 0, 0, 0);
    chk("seq F_pc", F_pc, 32'h3004);
    chk("seq D_pc", D_pc, 32'h3000);
    chk("seq D_instr", D_instr, 32'hF000_CFFF);
    cyc(32'h3008, 0, 0, 0, 0);
    chk("seq2 F_pc", F_pc, 32'h3008);
    chk("seq2 D_pc", D_pc, 32'h3004);
    cyc(32'h300C, 0, 0, 0, 0);
    cyc(32'h3010, 0, 0, 0, 0);

    // Three-cycle stall holds everything
    for (int i = 0; i < 3; i++) begin
      cyc(32'h3100, 1, 0, 0, 0);
      chk("stall F_pc", F_pc, 32'h3010);
      chk("stall D_pc", D_pc, 32'h300C);
    end
    cyc(32'h3014, 0, 0, 0, 0);
    chk("unstall F_pc", F_pc, 32'h3014);
    chk("unstall D_pc", D_pc, 32'h3010);
    cyc(32'h3018, 0, 0, 0, 0);
    cyc(32'h301C, 0, 0, 0, 0);
    cyc(32'h3020, 0, 0, 0, 0);

    // req beats stall
    cyc(32'h3024, 1, 1, 0, 0);
    chk("req F_pc", F_pc, 32'h4180);
    chk("req D_pc", D_pc, 32'h4180);
    chk("req D_instr", D_instr, 32'h0);
    // stale jump right after a flush is ignored
    cyc(32'h4184, 0, 0, 0, 1);
    chk("flushed D_bd", {31'd0, D_bd}, 32'd0);
    chk("flushed D_pc", D_pc, 32'h4180);
    cyc(32'h3040, 0, 0, 0, 0);

    // Delay slot marking
    cyc(32'h3044, 0, 0, 0, 1);
    chk("bd D_pc", D_pc, 32'h3040);
    chk("bd D_bd", {31'd0, D_bd}, 32'd1);
    cyc(32'h3048, 0, 0, 0, 0);
    chk("bd2 D_pc", D_pc, 32'h3044);
    chk("bd2 D_bd", {31'd0, D_bd}, 32'd0);

    // Fetch address errors: misaligned, above range
    cyc(32'h3002, 0, 0, 0, 0);
    chk("mis F_excCode", {27'd0, F_excCode}, {27'd0, ADEL_CODE});
    cyc(32'h7000, 0, 0, 0, 0);
    chk("mis D_excCode", {27'd0, D_excCode}, {27'd0, ADEL_CODE});
    chk("mis D_instr", D_instr, ADEL_ON ? 32'h0 : 32'hF002_CFFD);
    chk("hi F_excCode", {27'd0, F_excCode}, {27'd0, ADEL_CODE});
    cyc(32'h6FFC, 0, 0, 0, 0);
    chk("hi D_excCode", {27'd0, D_excCode}, {27'd0, ADEL_CODE});
    chk("top F_excCode", {27'd0, F_excCode}, 32'd0);
    cyc(32'h2FFC, 0, 0, 0, 0);
    chk("lo F_excCode", {27'd0, F_excCode}, {27'd0, ADEL_CODE});
    cyc(32'h3100, 0, 0, 0, 0);
    chk("lo D_pc", D_pc, 32'h2FFC);
    chk("ok F_excCode", {27'd0, F_excCode}, 32'd0);

    // ERET flush, then eret under stall, then stale jump
    cyc(32'h3104, 0, 0, 1, 0);
    chk("eret F_pc", F_pc, 32'h3104);
    chk("eret D_pc", D_pc, 32'h3100);
    chk("eret D_instr", D_instr, 32'h0);
    cyc(32'h3200, 1, 0, 1, 1);
    chk("eret stall F_pc", F_pc, 32'h3104);
    cyc(32'h3108, 0, 0, 0, 1);
    chk("eret bd", {31'd0, D_bd}, 32'd0);
    chk("eret2 D_pc", D_pc, 32'h3104);
    cyc(32'h3300, 0, 1, 1, 0);
    chk("req+eret F_pc", F_pc, 32'h4180);
    chk("req+eret D_pc", D_pc, 32'h4180);
    cyc(32'h4184, 0, 0, 0, 0);

    // Reset mid-cycle takes effect without a clock edge
    #2 reset = 1'b1;
    #1;
    chk("async F_pc", F_pc, 32'h3000);
    chk("async D_pc", D_pc, 32'h3000);
    chk("async D_instr", D_instr, 32'h0);
    @(negedge clk);
    #1 reset = 1'b0;
    cyc(32'h3004, 0, 0, 0, 0);
    chk("post F_pc", F_pc, 32'h3004);
    chk("post D_pc", D_pc, 32'h3000);

    @(negedge clk);
    chk_on = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
